// File: rtl/pcie_gen12_scramble.sv
// Gen1/Gen2 (8b/10b) PIPE transmit scrambler, one instance per lane.
// Handles 1..MAX_BYTES symbols per beat and applies the ordered-set rules:
// COM reseeds, SKP holds, the TS body passes in clear, and K-runs stay unscrambled.
//
// Handshake: data_valid_i is a pure qualifier and there is no ready. Every
// beat with data_valid_i = 1 is accepted on the clock edge that samples it.
// Beats with data_valid_i = 0 leave the LFSR and window state untouched but
// still move through the output pipeline, so data_valid_o is data_valid_i
// delayed by LATENCY cycles.
module pcie_gen12_scramble #(
    parameter int          MAX_BYTES = 4,
    parameter int          LATENCY   = 2,
    parameter logic [15:0] SEED      = 16'hFFFF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [8*MAX_BYTES-1:0] data_in_i,
    input  logic [MAX_BYTES-1:0]   data_k_in_i,
    input  logic                   data_valid_i,
    input  logic [5:0]             pipe_width_i,
    input  logic                   scramble_disable_i,
    output logic [8*MAX_BYTES-1:0] data_out_o,
    output logic [MAX_BYTES-1:0]   data_k_out_o,
    output logic                   data_valid_o,
    output logic [15:0]            lfsr_o,
    output logic [1:0]             os_state_o
);

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_PAD = 8'hF7;

    typedef enum logic [1:0] {
        OS_IDLE    = 2'd0,
        OS_PENDING = 2'd1,
        OS_TS      = 2'd2,
        OS_KRUN    = 2'd3
    } os_state_e;

    // Eight Galois shifts of x^16+x^5+x^4+x^3+1: the MSB feeds bit 0 and taps 3..5.
    function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
        logic [15:0] v;
        v = s;
        for (int n = 0; n < 8; n++) begin
            v = {v[14:0], v[15]} ^ (v[15] ? 16'h0038 : 16'h0000);
        end
        return v;
    endfunction

    // The scramble byte is LFSR[15:8] read LSB-first: bit n comes from LFSR[15-n].
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int n = 0; n < 8; n++) begin
            r[n] = b[7-n];
        end
        return r;
    endfunction

    logic [15:0]            r_lfsr;
    os_state_e              r_mode;
    logic [3:0]             r_off;

    logic [15:0]            w_lfsr;
    os_state_e              w_mode;
    os_state_e              w_eff;
    logic [3:0]             w_off;
    logic [7:0]             w_sym;
    logic                   w_is_k;
    logic                   w_scr;
    logic [8*MAX_BYTES-1:0] w_data;
    logic [MAX_BYTES-1:0]   w_k;
    logic [5:0]             w_nbytes;

    logic [8*MAX_BYTES-1:0] r_s1_data;
    logic [MAX_BYTES-1:0]   r_s1_k;
    logic                   r_s1_valid;

    assign w_nbytes   = pipe_width_i >> 3;
    assign lfsr_o     = r_lfsr;
    assign os_state_o = r_mode;

    // Byte-serial chain: LFSR and window state ripple from byte 0 upward.
    always_comb begin
        w_lfsr = r_lfsr;
        w_mode = r_mode;
        w_off  = r_off;
        w_eff  = OS_IDLE;
        w_sym  = 8'h00;
        w_is_k = 1'b0;
        w_scr  = 1'b0;
        w_data = '0;
        w_k    = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < int'(w_nbytes)) begin
                w_sym  = data_in_i[8*i +: 8];
                w_is_k = data_k_in_i[i];
                w_k[i] = w_is_k;
                if (w_is_k && (w_sym == K_COM)) begin
                    // COM reseeds in place of an advance and opens a fresh window.
                    w_data[8*i +: 8] = w_sym;
                    w_lfsr = SEED;
                    w_mode = OS_PENDING;
                    w_off  = 4'd1;
                end else begin
                    // The symbol right after COM decides TS body versus K-run.
                    w_eff = w_mode;
                    if (w_mode == OS_PENDING) begin
                        w_eff = (!w_is_k || (w_sym == K_PAD)) ? OS_TS : OS_KRUN;
                    end
                    w_scr = !w_is_k && (w_eff != OS_TS) && !scramble_disable_i;
                    w_data[8*i +: 8] = w_scr ? (w_sym ^ rev8(w_lfsr[15:8])) : w_sym;
                    if (!(w_is_k && (w_sym == K_SKP))) begin
                        w_lfsr = lfsr_adv8(w_lfsr);
                    end
                    case (w_eff)
                        OS_TS: begin
                            w_mode = (w_off == 4'd15) ? OS_IDLE : OS_TS;
                            w_off  = (w_off == 4'd15) ? 4'd15 : w_off + 4'd1;
                        end
                        OS_KRUN: begin
                            w_mode = w_is_k ? OS_KRUN : OS_IDLE;
                            w_off  = (w_off == 4'd15) ? 4'd15 : w_off + 4'd1;
                        end
                        default: w_mode = OS_IDLE;
                    endcase
                end
            end
        end
    end

    // LFSR and ordered-set window state advance only on accepted beats.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr <= SEED;
            r_mode <= OS_IDLE;
            r_off  <= 4'd0;
        end else if (data_valid_i) begin
            r_lfsr <= w_lfsr;
            r_mode <= w_mode;
            r_off  <= w_off;
        end
    end

    // First output stage; idle beats carry zero data and K.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_data  <= '0;
            r_s1_k     <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= data_valid_i;
            r_s1_data  <= data_valid_i ? w_data : '0;
            r_s1_k     <= data_valid_i ? w_k : '0;
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic [8*MAX_BYTES-1:0] r_s2_data;
            logic [MAX_BYTES-1:0]   r_s2_k;
            logic                   r_s2_valid;

            // Output retiming stage only.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_s2_data  <= '0;
                    r_s2_k     <= '0;
                    r_s2_valid <= 1'b0;
                end else begin
                    r_s2_data  <= r_s1_data;
                    r_s2_k     <= r_s1_k;
                    r_s2_valid <= r_s1_valid;
                end
            end

            assign data_out_o   = r_s2_data;
            assign data_k_out_o = r_s2_k;
            assign data_valid_o = r_s2_valid;
        end else begin : g_lat1
            assign data_out_o   = r_s1_data;
            assign data_k_out_o = r_s1_k;
            assign data_valid_o = r_s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_pcie_gen12_scramble.sv
// Bench for pcie_gen12_scramble: vector table, directed ordered-set sequences,
// random stream, with an output scoreboard fed from a bit-level reference model.
module tb_pcie_gen12_scramble;

    localparam int LATENCY = 2;
    localparam int W       = 37;

    logic        clk;
    logic        rst_i;
    logic [31:0] data_in_i;
    logic [3:0]  data_k_in_i;
    logic        data_valid_i;
    logic [5:0]  pipe_width_i;
    logic        scramble_disable_i;
    logic [31:0] data_out_o;
    logic [3:0]  data_k_out_o;
    logic        data_valid_o;
    logic [15:0] lfsr_o;
    logic [1:0]  os_state_o;

    pcie_gen12_scramble #(
        .MAX_BYTES (4),
        .LATENCY   (LATENCY),
        .SEED      (16'hFFFF)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .data_in_i          (data_in_i),
        .data_k_in_i        (data_k_in_i),
        .data_valid_i       (data_valid_i),
        .pipe_width_i       (pipe_width_i),
        .scramble_disable_i (scramble_disable_i),
        .data_out_o         (data_out_o),
        .data_k_out_o       (data_k_out_o),
        .data_valid_o       (data_valid_o),
        .lfsr_o             (lfsr_o),
        .os_state_o         (os_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    int          m_mode;   // 0 idle, 1 pending, 2 ts, 3 krun
    int          m_off;

    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] v;
        logic        nb;
        v = s;
        for (int j = 0; j < 8; j++) begin
            nb   = v[15];
            v    = v << 1;
            v[0] = nb;
            v[3] = v[3] ^ nb;
            v[4] = v[4] ^ nb;
            v[5] = v[5] ^ nb;
        end
        return v;
    endfunction

    function automatic logic [7:0] m_scr_byte(input logic [15:0] s);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = s[15-j];
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hFFFF;
        m_mode = 0;
        m_off  = 0;
    endtask

    task automatic model_beat(input logic [5:0] w, input logic [31:0] d, input logic [3:0] k,
                              input logic dis, output logic [31:0] od, output logic [3:0] ok);
        int         n;
        int         eff;
        logic [7:0] s;
        logic       kk;
        n  = int'(w) / 8;
        od = '0;
        ok = '0;
        for (int b = 0; b < n; b++) begin
            s  = d[8*b +: 8];
            kk = k[b];
            ok[b] = kk;
            od[8*b +: 8] = s;
            if (kk && s == 8'hBC) begin
                m_lfsr = 16'hFFFF;
                m_mode = 1;
                m_off  = 1;
            end else begin
                eff = m_mode;
                if (eff == 1) eff = (!kk || s == 8'hF7) ? 2 : 3;
                if (!kk && eff != 2 && !dis) od[8*b +: 8] = s ^ m_scr_byte(m_lfsr);
                if (!(kk && s == 8'h1C)) m_lfsr = m_step(m_lfsr);
                if (eff == 2) begin
                    m_mode = (m_off == 15) ? 0 : 2;
                    if (m_off < 15) m_off++;
                end else if (eff == 3) begin
                    m_mode = kk ? 3 : 0;
                    if (m_off < 15) m_off++;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [5:0] w, input logic [31:0] d, input logic [3:0] k,
                         input logic v, input logic dis, input logic use_tbl,
                         input logic [31:0] td, input logic [3:0] tk);
        logic [31:0] md;
        logic [3:0]  mk;
        @(negedge clk);
        pipe_width_i       = w;
        data_in_i          = d;
        data_k_in_i        = k;
        data_valid_i       = v;
        scramble_disable_i = dis;
        md = '0;
        mk = '0;
        if (v) model_beat(w, d, k, dis, md, mk);
        if (use_tbl) begin
            md = td;
            mk = tk;
        end
        exp_q.push_back({v, mk, md});
        @(posedge clk);
        #1;
        checks++;
        if (lfsr_o !== m_lfsr) begin
            failures++;
            $display("FAIL lfsr t=%0t got=%h exp=%h", $time, lfsr_o, m_lfsr);
        end
        checks++;
        if (int'(os_state_o) != m_mode) begin
            failures++;
            $display("FAIL os_state t=%0t got=%0d exp=%0d", $time, os_state_o, m_mode);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i              = 1'b1;
        data_valid_i       = 1'b1;
        data_in_i          = 32'h5A5A5A5A;
        data_k_in_i        = 4'h0;
        scramble_disable_i = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        checks++;
        if (data_out_o !== 32'h0 || data_k_out_o !== 4'h0 || data_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got=%h/%h/%b exp=0/0/0", data_out_o, data_k_out_o, data_valid_o);
        end
        checks++;
        if (lfsr_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_lfsr got=%h exp=ffff", lfsr_o);
        end
        checks++;
        if (os_state_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", os_state_o);
        end
        @(negedge clk);
        rst_i        = 1'b0;
        data_valid_i = 1'b0;
        model_reset();
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (!rst_i && exp_q.size() >= LATENCY) begin
            exp_e = exp_q.pop_front();
            checks++;
            if (data_valid_o !== exp_e[36]) begin
                failures++;
                $display("FAIL valid_out t=%0t got=%b exp=%b", $time, data_valid_o, exp_e[36]);
            end
            if (exp_e[36]) begin
                checks++;
                if (data_out_o !== exp_e[31:0]) begin
                    failures++;
                    $display("FAIL data_out t=%0t got=%h exp=%h", $time, data_out_o, exp_e[31:0]);
                end
                checks++;
                if (data_k_out_o !== exp_e[35:32]) begin
                    failures++;
                    $display("FAIL k_out t=%0t got=%h exp=%h", $time, data_k_out_o, exp_e[35:32]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [5:0]  width;
        logic [31:0] data;
        logic [3:0]  k;
        logic        valid;
        logic        dis;
        logic [31:0] exp_data;
        logic [3:0]  exp_k;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] d;
        logic [3:0]  k;
        logic [7:0]  sym;

        vecs[0]  = '{6'd32, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'h14C017FF, 4'h0};
        vecs[1]  = '{6'd32, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'h8202E7B2, 4'h0};
        vecs[2]  = '{6'd32, 32'h1C1C1CBC, 4'hF, 1'b1, 1'b0, 32'h1C1C1CBC, 4'hF};
        vecs[3]  = '{6'd32, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'h14C017FF, 4'h0};
        vecs[4]  = '{6'd32, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'h8202E7B2, 4'h0};
        vecs[5]  = '{6'd16, 32'h00000000, 4'h0, 1'b0, 1'b0, 32'h00000000, 4'h0};
        vecs[6]  = '{6'd16, 32'h00001CBC, 4'h3, 1'b1, 1'b0, 32'h00001CBC, 4'h3};
        vecs[7]  = '{6'd16, 32'hAAAA0000, 4'hC, 1'b1, 1'b0, 32'h000017FF, 4'h0};
        vecs[8]  = '{6'd16, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'h000014C0, 4'h0};
        vecs[9]  = '{6'd8,  32'h00000000, 4'h0, 1'b0, 1'b0, 32'h00000000, 4'h0};
        vecs[10] = '{6'd8,  32'h000000BC, 4'h1, 1'b1, 1'b0, 32'h000000BC, 4'h1};
        vecs[11] = '{6'd8,  32'h0000001C, 4'h1, 1'b1, 1'b0, 32'h0000001C, 4'h1};
        vecs[12] = '{6'd8,  32'h00000000, 4'h0, 1'b1, 1'b0, 32'h000000FF, 4'h0};
        vecs[13] = '{6'd8,  32'h00000000, 4'h0, 1'b1, 1'b1, 32'h00000000, 4'h0};
        vecs[14] = '{6'd8,  32'h00000000, 4'h0, 1'b1, 1'b0, 32'h000000C0, 4'h0};
        vecs[15] = '{6'd8,  32'hFFFFFF55, 4'hE, 1'b1, 1'b0, 32'h00000041, 4'h0};

        rst_i              = 1'b1;
        data_in_i          = '0;
        data_k_in_i        = '0;
        data_valid_i       = 1'b0;
        pipe_width_i       = 6'd32;
        scramble_disable_i = 1'b0;
        model_reset();

        do_reset();

        // Vector table: known scrambler sequence, SKP hold, width changes, disable.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].width, vecs[i].data, vecs[i].k, vecs[i].valid, vecs[i].dis,
                  1'b1, vecs[i].exp_data, vecs[i].exp_k);
        end

        // Width 8: COM, TS body of random D symbols in clear, then scrambled tail.
        drive(6'd8, 32'h000000BC, 4'h1, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 15; i++) drive(6'd8, $urandom(), 4'h0, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++)  drive(6'd8, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Width 16: COM on the last active byte, PAD opens the TS1 body in the next beat.
        drive(6'd16, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(6'd16, {16'($urandom()), 8'hBC, 8'($urandom())}, 4'b0010, 1'b1, 1'b0, 1'b0, '0, '0);
        drive(6'd16, {16'($urandom()), 8'($urandom()), 8'hF7}, 4'b0001, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 9; i++) drive(6'd16, $urandom(), 4'b0000, 1'b1, 1'b0, 1'b0, '0, '0);

        // Width 8: scrambling disabled for three beats mid-stream.
        drive(6'd8, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            drive(6'd8, 32'h0, 4'h0, 1'b1, (i >= 3 && i < 6), 1'b0, '0, '0);
        end

        // Stall: five idle cycles with junk on the data lines.
        for (int i = 0; i < 3; i++) drive(6'd8, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) drive(6'd8, $urandom(), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) drive(6'd8, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Reset inside an open TS window; the following zeros scramble from FF again.
        drive(6'd8, 32'h000000BC, 4'h1, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) drive(6'd8, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, '0, '0);
        do_reset();
        drive(6'd8, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h000000FF, 4'h0);
        drive(6'd8, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h00000017, 4'h0);
        drive(6'd8, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h000000C0, 4'h0);
        drive(6'd8, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h00000014, 4'h0);

        // Width 32: two COMs in one beat, last one reseeds.
        drive(6'd32, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(6'd32, 32'h00BC00BC, 4'b0101, 1'b1, 1'b0, 1'b0, '0, '0);
        drive(6'd32, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Random stream with ordered-set K symbols, stalls and disable.
        for (int i = 0; i < 60; i++) begin
            d = '0;
            k = '0;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 99) < 15) begin
                    case ($urandom_range(0, 3))
                        0:       sym = 8'hBC;
                        1:       sym = 8'h1C;
                        2:       sym = 8'hF7;
                        default: sym = 8'h7C;
                    endcase
                    k[b] = 1'b1;
                end else begin
                    sym = 8'($urandom_range(0, 255));
                end
                d[8*b +: 8] = sym;
            end
            drive(6'd32, d, k, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), 1'b0, '0, '0);
        end

        for (int i = 0; i < LATENCY + 1; i++) drive(6'd32, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
